// File: rtl/dl_arbiter_if.sv
// Requester / delay-line bundle for dl_arbiter.
// The arbiter takes the slave view; the requester/delay-line side takes the master view.
interface dl_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 15,
    parameter int unsigned LAT  = 5
);
    localparam int unsigned CW = $clog2(LAT + 1);

    logic                en;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_data;
    logic [NREQ-1:0]     req_ready;
    logic [W-1:0]        dl_d_in;
    logic [W-1:0]        dl_d_out;
    logic [NREQ-1:0]     rsp_valid;
    logic [W-1:0]        rsp_data;
    logic [CW-1:0]       inflight;

    modport slave (
        input  en, req_valid, req_data, dl_d_out,
        output req_ready, dl_d_in, rsp_valid, rsp_data, inflight
    );

    modport master (
        output en, req_valid, req_data, dl_d_out,
        input  req_ready, dl_d_in, rsp_valid, rsp_data, inflight
    );
endinterface

// File: rtl/dl_arbiter.sv
// Round-robin scheduler feeding a fixed-latency delay line; a shadow tag pipeline
// follows each word so the delay-line output is routed back to its issuer.
module dl_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 15,
    parameter int unsigned LAT  = 5
) (
    input  logic        clk,
    input  logic        rst,
    dl_arbiter_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(LAT + 1);

    logic [IW-1:0]   r_last;
    logic [LAT-1:0]  r_vld;
    logic [IW-1:0]   r_id [LAT];
    logic [CW-1:0]   r_inflight;

    logic            w_gany;
    logic [IW-1:0]   w_gidx;
    logic [IW-1:0]   w_cand;
    logic [NREQ-1:0] w_grant;
    logic [W-1:0]    w_din;
    logic [NREQ-1:0] w_rsp_valid;

    // Search begins one past the last winner and wraps; first valid requester wins.
    always_comb begin
        w_gany  = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        w_grant = '0;
        w_din   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_cand = IW'((32'(r_last) + 32'd1 + k) % NREQ);
            if (!w_gany && bus.req_valid[w_cand]) begin
                w_gany = 1'b1;
                w_gidx = w_cand;
            end
        end
        if (!bus.en || !rst) begin
            w_gany = 1'b0;
            w_gidx = '0;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gany && (w_gidx == IW'(i))) begin
                w_grant[i] = 1'b1;
                w_din      = bus.req_data[i*W +: W];
            end
        end
    end

    always_comb begin
        w_rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_rsp_valid[i] = r_vld[LAT-1] && (r_id[LAT-1] == IW'(i));
        end
    end

    // Tags shift every edge with no stall, matching the delay line stage for stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last     <= IW'(NREQ - 1);
            r_vld      <= '0;
            r_inflight <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                r_id[k] <= '0;
            end
        end else begin
            if (w_gany) begin
                r_last <= w_gidx;
            end
            r_vld[0] <= w_gany;
            r_id[0]  <= w_gidx;
            for (int unsigned k = 1; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_id[k]  <= r_id[k-1];
            end
            r_inflight <= r_inflight + CW'(w_gany) - CW'(r_vld[LAT-1]);
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.dl_d_in   = w_din;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = bus.dl_d_out;
    assign bus.inflight  = r_inflight;
endmodule

// File: tb/tb_dl_arbiter.sv
// Self-checking bench for dl_arbiter: directed vector table plus a randomized
// scoreboard run against a reference round-robin model and a model delay line.
module tb_dl_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 15;
    localparam int unsigned LAT  = 5;

    localparam logic [59:0] Z  = 60'h0;
    localparam logic [59:0] DA = {45'h0, 15'h1234};
    localparam logic [59:0] D4 = {15'h0103, 15'h0102, 15'h0101, 15'h0100};
    localparam logic [59:0] D2 = {15'h0203, 15'h0202, 15'h0201, 15'h0200};

    typedef struct {
        bit          rst;
        logic        en;
        logic [3:0]  vld;
        logic [59:0] data;
        logic [3:0]  rdy;
        logic [14:0] din;
        logic [3:0]  rv;
        logic [14:0] rd;
        logic [2:0]  inf;
    } vec_t;

    typedef struct {
        int unsigned id;
        logic [14:0] data;
        int          due;
    } sb_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    vec_t tbl[$];
    sb_t  q[$];
    logic [14:0] r_dl [LAT];

    dl_arbiter_if #(.NREQ(NREQ), .W(W), .LAT(LAT)) bus ();

    dl_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the external delay line sharing reset with the arbiter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LAT; k++) r_dl[k] <= '0;
        end else begin
            r_dl[0] <= bus.dl_d_in;
            for (int k = 1; k < LAT; k++) r_dl[k] <= r_dl[k-1];
        end
    end
    assign bus.dl_d_out = r_dl[LAT-1];

    function automatic vec_t mk(bit r, logic e, logic [3:0] v, logic [59:0] d,
                                logic [3:0] rdy, logic [14:0] din, logic [3:0] rv,
                                logic [14:0] rd, logic [2:0] inf);
        vec_t x;
        x.rst = r; x.en = e; x.vld = v; x.data = d;
        x.rdy = rdy; x.din = din; x.rv = rv; x.rd = rd; x.inf = inf;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.en = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data = D4;
        #1;
        chk("reset req_ready", 64'(bus.req_ready), 64'h0);
        chk("reset dl_d_in",   64'(bus.dl_d_in),   64'h0);
        chk("reset rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("reset inflight",  64'(bus.inflight),  64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int n);
        if (v.rst) do_reset();
        bus.en = v.en;
        bus.req_valid = v.vld;
        bus.req_data = v.data;
        #1;
        chk($sformatf("row%0d req_ready", n), 64'(bus.req_ready), 64'(v.rdy));
        chk($sformatf("row%0d dl_d_in",   n), 64'(bus.dl_d_in),   64'(v.din));
        chk($sformatf("row%0d rsp_valid", n), 64'(bus.rsp_valid), 64'(v.rv));
        chk($sformatf("row%0d rsp_data",  n), 64'(bus.rsp_data),  64'(v.rd));
        chk($sformatf("row%0d inflight",  n), 64'(bus.inflight),  64'(v.inf));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.en = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;

        // Single word from requester 0: response 4 edges after the handshake edge.
        tbl.push_back(mk(1, 1, 4'b0001, DA, 4'b0001, 15'h1234, 4'b0000, 15'h0000, 3'd0));
        repeat (4) tbl.push_back(mk(0, 1, 4'b0000, Z, 4'b0000, 15'h0, 4'b0000, 15'h0, 3'd1));
        tbl.push_back(mk(0, 1, 4'b0000, Z, 4'b0000, 15'h0, 4'b0001, 15'h1234, 3'd1));
        tbl.push_back(mk(0, 1, 4'b0000, Z, 4'b0000, 15'h0, 4'b0000, 15'h0, 3'd0));

        // All valid: strict rotation, then en drops while words drain.
        tbl.push_back(mk(1, 1, 4'hF, D4, 4'b0001, 15'h100, 4'b0000, 15'h000, 3'd0));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b0010, 15'h101, 4'b0000, 15'h000, 3'd1));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b0100, 15'h102, 4'b0000, 15'h000, 3'd2));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b1000, 15'h103, 4'b0000, 15'h000, 3'd3));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b0001, 15'h100, 4'b0000, 15'h000, 3'd4));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b0010, 15'h101, 4'b0001, 15'h100, 3'd5));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b0100, 15'h102, 4'b0010, 15'h101, 3'd5));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b1000, 15'h103, 4'b0100, 15'h102, 3'd5));
        tbl.push_back(mk(0, 0, 4'hF, D4, 4'b0000, 15'h000, 4'b1000, 15'h103, 3'd5));
        tbl.push_back(mk(0, 0, 4'hF, D4, 4'b0000, 15'h000, 4'b0001, 15'h100, 3'd4));
        tbl.push_back(mk(0, 0, 4'hF, D4, 4'b0000, 15'h000, 4'b0010, 15'h101, 3'd3));
        tbl.push_back(mk(0, 0, 4'hF, D4, 4'b0000, 15'h000, 4'b0100, 15'h102, 3'd2));
        tbl.push_back(mk(0, 0, 4'hF, D4, 4'b0000, 15'h000, 4'b1000, 15'h103, 3'd1));
        tbl.push_back(mk(0, 0, 4'hF, D4, 4'b0000, 15'h000, 4'b0000, 15'h000, 3'd0));
        tbl.push_back(mk(0, 0, 4'hF, D4, 4'b0000, 15'h000, 4'b0000, 15'h000, 3'd0));
        // en back high: rotation resumes after last winner (3), so 0 then 1.
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b0001, 15'h100, 4'b0000, 15'h000, 3'd0));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b0010, 15'h101, 4'b0000, 15'h000, 3'd1));
        repeat (3) tbl.push_back(mk(0, 1, 4'h0, Z, 4'b0000, 15'h0, 4'b0000, 15'h0, 3'd2));
        tbl.push_back(mk(0, 1, 4'h0, Z, 4'b0000, 15'h0, 4'b0001, 15'h100, 3'd2));
        tbl.push_back(mk(0, 1, 4'h0, Z, 4'b0000, 15'h0, 4'b0010, 15'h101, 3'd1));
        tbl.push_back(mk(0, 1, 4'h0, Z, 4'b0000, 15'h0, 4'b0000, 15'h0, 3'd0));

        // Requester 2 alone, then requester 1 joins: alternation 1,2,1,2.
        tbl.push_back(mk(1, 1, 4'b0100, D2, 4'b0100, 15'h202, 4'b0000, 15'h000, 3'd0));
        tbl.push_back(mk(0, 1, 4'b0100, D2, 4'b0100, 15'h202, 4'b0000, 15'h000, 3'd1));
        tbl.push_back(mk(0, 1, 4'b0100, D2, 4'b0100, 15'h202, 4'b0000, 15'h000, 3'd2));
        tbl.push_back(mk(0, 1, 4'b0100, D2, 4'b0100, 15'h202, 4'b0000, 15'h000, 3'd3));
        tbl.push_back(mk(0, 1, 4'b0100, D2, 4'b0100, 15'h202, 4'b0000, 15'h000, 3'd4));
        tbl.push_back(mk(0, 1, 4'b0100, D2, 4'b0100, 15'h202, 4'b0100, 15'h202, 3'd5));
        tbl.push_back(mk(0, 1, 4'b0110, D2, 4'b0010, 15'h201, 4'b0100, 15'h202, 3'd5));
        tbl.push_back(mk(0, 1, 4'b0110, D2, 4'b0100, 15'h202, 4'b0100, 15'h202, 3'd5));
        tbl.push_back(mk(0, 1, 4'b0110, D2, 4'b0010, 15'h201, 4'b0100, 15'h202, 3'd5));
        tbl.push_back(mk(0, 1, 4'b0110, D2, 4'b0100, 15'h202, 4'b0100, 15'h202, 3'd5));
        tbl.push_back(mk(0, 1, 4'b0000, Z,  4'b0000, 15'h000, 4'b0100, 15'h202, 3'd5));
        tbl.push_back(mk(0, 1, 4'b0000, Z,  4'b0000, 15'h000, 4'b0010, 15'h201, 3'd4));
        tbl.push_back(mk(0, 1, 4'b0000, Z,  4'b0000, 15'h000, 4'b0100, 15'h202, 3'd3));
        tbl.push_back(mk(0, 1, 4'b0000, Z,  4'b0000, 15'h000, 4'b0010, 15'h201, 3'd2));
        tbl.push_back(mk(0, 1, 4'b0000, Z,  4'b0000, 15'h000, 4'b0100, 15'h202, 3'd1));
        tbl.push_back(mk(0, 1, 4'b0000, Z,  4'b0000, 15'h000, 4'b0000, 15'h000, 3'd0));

        // Three words in flight, then reset: no responses, priority back to 0.
        tbl.push_back(mk(1, 1, 4'hF, D4, 4'b0001, 15'h100, 4'b0000, 15'h000, 3'd0));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b0010, 15'h101, 4'b0000, 15'h000, 3'd1));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b0100, 15'h102, 4'b0000, 15'h000, 3'd2));
        tbl.push_back(mk(1, 1, 4'h0, Z,  4'b0000, 15'h000, 4'b0000, 15'h000, 3'd0));
        repeat (9) tbl.push_back(mk(0, 1, 4'h0, Z, 4'b0000, 15'h0, 4'b0000, 15'h0, 3'd0));
        tbl.push_back(mk(0, 1, 4'hF, D4, 4'b0001, 15'h100, 4'b0000, 15'h000, 3'd0));

        @(posedge clk); #1;
        foreach (tbl[n]) apply(tbl[n], n);

        // Randomized traffic against a reference round-robin and an ordered scoreboard.
        begin
            int unsigned last_m;
            int          cyc;
            logic [3:0]  v;
            logic        e;
            logic [59:0] d;
            logic [3:0]  exp_rdy;
            logic [14:0] exp_din;
            int unsigned gidx;
            bit          gany;
            sb_t         s;

            do_reset();
            last_m = NREQ - 1;
            cyc = 0;
            for (int it = 0; it < 2008; it++) begin
                v = (it < 2000) ? 4'($urandom_range(0, 15)) : 4'h0;
                e = ($urandom_range(0, 9) != 0);
                d = {$urandom, $urandom};
                bus.en = e;
                bus.req_valid = v;
                bus.req_data = d;
                #1;
                gany = 1'b0;
                gidx = 0;
                if (e) begin
                    for (int unsigned k = 0; k < NREQ; k++) begin
                        int unsigned c;
                        c = (last_m + 1 + k) % NREQ;
                        if (!gany && v[c]) begin
                            gany = 1'b1;
                            gidx = c;
                        end
                    end
                end
                exp_rdy = gany ? 4'(1 << gidx) : 4'h0;
                exp_din = gany ? d[gidx*W +: W] : 15'h0;
                chk($sformatf("rnd%0d req_ready", it), 64'(bus.req_ready), 64'(exp_rdy));
                chk($sformatf("rnd%0d dl_d_in",   it), 64'(bus.dl_d_in),   64'(exp_din));
                chk($sformatf("rnd%0d inflight",  it), 64'(bus.inflight),  64'(q.size()));
                if (q.size() > 0 && q[0].due == cyc) begin
                    s = q.pop_front();
                    chk($sformatf("rnd%0d rsp_valid", it), 64'(bus.rsp_valid), 64'(1 << s.id));
                    chk($sformatf("rnd%0d rsp_data",  it), 64'(bus.rsp_data),  64'(s.data));
                end else begin
                    chk($sformatf("rnd%0d rsp_idle", it), 64'(bus.rsp_valid), 64'h0);
                end
                if (gany) begin
                    s.id = gidx;
                    s.data = exp_din;
                    s.due = cyc + LAT;
                    q.push_back(s);
                    last_m = gidx;
                end
                @(posedge clk); #1;
                cyc++;
            end
            chk("rnd scoreboard drained", 64'(q.size()), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
